imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the core's fetch stage. Each cycle it compares the fetch PC against its fill buffer. On a hit it presents the instruction combinationally with stall deasserted. On a miss it holds stall high and fills the buffer from an internal word array after a programmable number of wait states. A side port loads program words and keeps the buffer coherent with those writes.

## Interface
- DEPTH_WORDS, 1024: instruction array size in 32-bit words (power of two, ≥4)
- WAIT_STATES, 1: extra access cycles per fill (0..15)

- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- req_en  input  1  fetch stage active; stall and fills are suppressed when low
- pc_in  input  32  fetch PC; word index = pc_in[31:2], bits [1:0] ignored
- instr_out  output  32  instruction for pc_in, valid when stall_out=0
- stall_out  output  1  high while pc_in misses
- fault_out  output  1  the hit word lies beyond DEPTH_WORDS
- busy_out  output  1  FSM not IDLE
- prog_we  input  1  program-load write strobe
- prog_addr  input  32  load word index (entire 32 bits)
- prog_wdata  input  32  load data

## Operation
- Storage: mem[0:DEPTH_WORDS-1] of 32-bit words, not reset.
- Buffer entry E0:
  - valid, addr[29:0], data[31:0] and fault bit.
  - valid resets to 0.
- hit = E0.valid && E0.addr == pc_in[31:2].
- Output equations:
  - stall_out = rst_n & req_en & !hit
  - instr_out = hit ? E0.data : 0
  - fault_out = hit & E0.fault
- FSM states are IDLE and BUSY, plus counter cnt[3:0].
- IDLE:
  - Taken when req_en && !hit and no prog_we hits the access address.
  - Latch acc_addr = pc_in[31:2] and set cnt = WAIT_STATES.
  - Go to BUSY.
- BUSY:
  - When cnt≠0: cnt−1.
  - When cnt==0: fill E0 with addr=acc_addr, data = mem[acc_addr] (0 if acc_addr ≥ DEPTH_WORDS), fault = (acc_addr ≥ DEPTH_WORDS), valid=1. Then go to IDLE.
- pc_in changing during BUSY (branch redirect):
  - The access is not aborted and completes to the old address.
  - The new PC misses in the following IDLE cycle and starts its own access.
- Program write, prog_we with prog_addr < DEPTH_WORDS:
  - mem[prog_addr] ← prog_wdata.
  - Writes at or above DEPTH_WORDS are dropped.
  - If E0.valid and E0.addr==prog_addr, E0.valid ← 0.
- Write and fill collide: if a write and a BUSY fill target the same address in the same cycle, the write wins. mem is updated, E0.valid ends at 0, and the next IDLE cycle refetches.
- req_en low: no new access starts. An access already in BUSY completes.

## Timing
- Reset values:
  - instr_out 0
  - stall_out 0
  - fault_out 0
  - busy_out 0
  - FSM IDLE, cnt 0, E0.valid 0
- Miss detected in cycle 0:
  - BUSY lasts WAIT_STATES+1 cycles.
  - Hit is visible in cycle WAIT_STATES+2.
  - stall_out is high for WAIT_STATES+2 cycles.
- Hit: zero-cycle combinational response, no stall.
- Asynchronous reset mid-BUSY: the access is dropped, the buffer is invalidated and the FSM returns to IDLE.

## Configuration
- IMEM_PREFETCH_EN defined, adds entry E1 (same fields):
  - hit = E0 hit or E1 hit. On a dual match, E0 takes priority.
  - In IDLE with no demand miss, start a prefetch of word E0.addr+1 when E0.valid and E1 does not already hold that word. The prefetch completes into E1.
  - A demand miss arriving during a prefetch BUSY waits for the prefetch to finish, then starts.
  - A demand fill goes to E0.
  - A prog_we match invalidates either entry.
- IMEM_PREFETCH_EN undefined: E1 and prefetch logic are absent, behaviour as above.

## Test plan
- Initial miss:
  - Stimulus: WAIT_STATES=1, mem[0]=0xE3A0_0001, release reset with req_en=1, pc_in=0.
  - Response: stall_out high for 3 cycles, then instr_out=0xE3A0_0001 and stall_out=0.
- Sequential stream:
  - Stimulus: pc_in 0x0→0x4→0x8.
  - Response without prefetch: each word costs 3 stall cycles.
  - Response with IMEM_PREFETCH_EN: 0x4 hits with 0 stall once the prefetch is complete.
- Redirect during BUSY:
  - Stimulus: pc_in moves from 0x10 to 0x40 mid-access.
  - Response: the 0x10 fill completes, then 0x40 misses and returns mem[16] after 3 further stall cycles.
- Write coherence:
  - Stimulus: hit on 0x20, then prog_we to prog_addr=8 with data 0xDEAD_BEEF.
  - Response: the next cycle misses, then instr_out=0xDEAD_BEEF.
- Out of range:
  - Stimulus: DEPTH_WORDS=1024, pc_in=0x0000_1000.
  - Response: instr_out=0 and fault_out=1 after the fill.
- Reset mid-access:
  - Stimulus: assert rst_n low in the second BUSY cycle.
  - Response: stall_out and busy_out drop immediately, and the original PC misses again after release.

Source files
------------

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch and program-load bus between the core and the instruction memory responder
interface imem_responder_if;
  logic        req_en;
  logic [31:0] pc_in;
  logic [31:0] instr_out;
  logic        stall_out;
  logic        fault_out;
  logic        busy_out;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  modport master (
    output req_en, pc_in, prog_we, prog_addr, prog_wdata,
    input  instr_out, stall_out, fault_out, busy_out
  );

  modport slave (
    input  req_en, pc_in, prog_we, prog_addr, prog_wdata,
    output instr_out, stall_out, fault_out, busy_out
  );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-side instruction memory with fill buffer and wait-state fills
// Optional next-word prefetch entry E1 is built when IMEM_PREFETCH_EN is defined.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst_n,
  imem_responder_if.slave bus
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [29:0] acc_addr_q;
  logic        e0_valid_q;
  logic [29:0] e0_addr_q;
  logic [31:0] e0_data_q;
  logic        e0_fault_q;

  logic [29:0] pc_word;
  logic        wr_ok, wr_pc, wr_e0, wr_acc;
  logic        e0_hit, hit, start_dem, fill_now, fill_e0;
  logic [31:0] fill_data_d;
  logic        fill_fault_d;
  logic        unused_pc_bits;

  assign pc_word        = bus.pc_in[31:2];
  assign unused_pc_bits = &{1'b0, bus.pc_in[1:0]};

  assign wr_ok  = bus.prog_we && (bus.prog_addr < DEPTH);
  assign wr_pc  = bus.prog_we && (bus.prog_addr == {2'b00, pc_word});
  assign wr_e0  = wr_ok && (bus.prog_addr == {2'b00, e0_addr_q});
  assign wr_acc = wr_ok && (bus.prog_addr == {2'b00, acc_addr_q});

  assign e0_hit   = e0_valid_q && (e0_addr_q == pc_word);
  assign fill_now = (state_q == BUSY) && (cnt_q == 4'd0);

  assign fill_fault_d = ({2'b00, acc_addr_q} >= DEPTH);
  assign fill_data_d  = fill_fault_d ? 32'd0 : mem[acc_addr_q[AW-1:0]];

`ifdef IMEM_PREFETCH_EN
  logic        e1_valid_q;
  logic [29:0] e1_addr_q;
  logic [31:0] e1_data_q;
  logic        e1_fault_q;
  logic        pf_q;
  logic        e1_hit, wr_e1, start_pf, fill_e1;
  logic [29:0] pf_addr;

  assign pf_addr  = e0_addr_q + 30'd1;
  assign e1_hit   = e1_valid_q && (e1_addr_q == pc_word);
  assign wr_e1    = wr_ok && (bus.prog_addr == {2'b00, e1_addr_q});
  assign hit      = e0_hit || e1_hit;
  assign start_pf = bus.req_en && e0_valid_q && !(e1_valid_q && (e1_addr_q == pf_addr));
  assign fill_e0  = fill_now && !pf_q;
  assign fill_e1  = fill_now && pf_q;

  // E0 wins a dual match
  assign bus.instr_out = e0_hit ? e0_data_q : (e1_hit ? e1_data_q : 32'd0);
  assign bus.fault_out = e0_hit ? e0_fault_q : (e1_hit && e1_fault_q);
`else
  assign hit           = e0_hit;
  assign fill_e0       = fill_now;
  assign bus.instr_out = e0_hit ? e0_data_q : 32'd0;
  assign bus.fault_out = e0_hit && e0_fault_q;
`endif

  assign start_dem     = bus.req_en && !hit && !wr_pc;
  assign bus.stall_out = rst_n && bus.req_en && !hit;
  assign bus.busy_out  = (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.prog_addr[AW-1:0]] <= bus.prog_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      acc_addr_q <= 30'd0;
      e0_valid_q <= 1'b0;
      e0_addr_q  <= 30'd0;
      e0_data_q  <= 32'd0;
      e0_fault_q <= 1'b0;
`ifdef IMEM_PREFETCH_EN
      e1_valid_q <= 1'b0;
      e1_addr_q  <= 30'd0;
      e1_data_q  <= 32'd0;
      e1_fault_q <= 1'b0;
      pf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_dem) begin
            acc_addr_q <= pc_word;
            cnt_q      <= 4'(WAIT_STATES);
            state_q    <= BUSY;
`ifdef IMEM_PREFETCH_EN
            pf_q       <= 1'b0;
          end else if (start_pf) begin
            acc_addr_q <= pf_addr;
            cnt_q      <= 4'(WAIT_STATES);
            state_q    <= BUSY;
            pf_q       <= 1'b1;
`endif
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else               state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A same-cycle program write to the filled word leaves the entry invalid so it refetches
      if (fill_e0) begin
        e0_addr_q  <= acc_addr_q;
        e0_data_q  <= fill_data_d;
        e0_fault_q <= fill_fault_d;
        e0_valid_q <= !wr_acc;
      end else if (wr_e0) begin
        e0_valid_q <= 1'b0;
      end
`ifdef IMEM_PREFETCH_EN
      if (fill_e1) begin
        e1_addr_q  <= acc_addr_q;
        e1_data_q  <= fill_data_d;
        e1_fault_q <= fill_fault_d;
        e1_valid_q <= !wr_acc;
      end else if (wr_e1) begin
        e1_valid_q <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - vector tables, corner sequences and random run against a cycle-count model
module tb_imem_responder;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;
  localparam int NPRE  = 64;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        we;
    logic [31:0] pa;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] instr;
    logic        fault;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [NPRE];

  imem_responder_if bus ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic we,
                              input logic [31:0] pa, input logic [31:0] wd, input logic stall,
                              input logic [31:0] instr, input logic fault, input logic busy);
    vec_t v;
    v.req = req; v.pc = pc; v.we = we; v.pa = pa; v.wd = wd;
    v.stall = stall; v.instr = instr; v.fault = fault; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input string nm, input vec_t v);
    bus.req_en = v.req; bus.pc_in = v.pc;
    bus.prog_we = v.we; bus.prog_addr = v.pa; bus.prog_wdata = v.wd;
    @(negedge clk);
    chk({nm, ".stall"}, 32'(bus.stall_out), 32'(v.stall));
    chk({nm, ".instr"}, bus.instr_out, v.instr);
    chk({nm, ".fault"}, 32'(bus.fault_out), 32'(v.fault));
    chk({nm, ".busy"},  32'(bus.busy_out), 32'(v.busy));
    @(posedge clk); #1;
  endtask

  // miss on pc, W+1 busy cycles, then a hit returning data/fault
  task automatic miss_then_hit(input string nm, input logic [31:0] pc, input logic [31:0] d, input logic f);
    apply({nm, ".c0"}, mk(1, pc, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= WS + 1; k++) apply($sformatf("%s.c%0d", nm, k), mk(1, pc, 0, 0, 0, 1, 0, 0, 1));
    apply({nm, ".hit"}, mk(1, pc, 0, 0, 0, 0, d, f, 0));
  endtask

  // Reference model: entry plus one pending access with its completion cycle
  logic        m_valid, m_fault, m_busy;
  logic [29:0] m_addr, m_acc;
  logic [31:0] m_data;
  int          m_done, cyc;

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_addr = 0; m_acc = 0; m_data = 0; m_fault = 0;
    m_done = 0; cyc = 0;
  endtask

  task automatic model_step(input logic req, input logic [31:0] pc, input logic we,
                            input logic [31:0] pa, input logic [31:0] wd);
    logic hit, busy_pre, wr_ok;
    hit      = m_valid && (m_addr == pc[31:2]);
    busy_pre = m_busy;
    wr_ok    = we && (pa < DEPTH);
    if (m_busy && cyc == m_done) begin
      m_addr  = m_acc;
      m_fault = (m_acc >= DEPTH);
      m_data  = m_fault ? 32'd0 : ref_mem[m_acc];
      m_valid = !(wr_ok && pa == {2'b00, m_acc});
      m_busy  = 0;
    end else if (wr_ok && m_valid && pa == {2'b00, m_addr}) begin
      m_valid = 0;
    end
    if (!busy_pre && req && !hit && !(we && pa == {2'b00, pc[31:2]})) begin
      m_busy = 1;
      m_acc  = pc[31:2];
      m_done = cyc + WS + 1;
    end
    if (wr_ok) ref_mem[pa] = wd;
    cyc++;
  endtask

  vec_t tbl[$];

  initial begin
    logic [29:0] words [18];
    logic [31:0] cur_pc;

    rst_n = 1'b0;
    bus.req_en = 1; bus.pc_in = 0; bus.prog_we = 0; bus.prog_addr = 0; bus.prog_wdata = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NPRE; i++) begin
      ref_mem[i]     = (i == 0) ? 32'hE3A0_0001 : (32'h1000_0000 | 32'(i));
      bus.prog_we    = 1;
      bus.prog_addr  = 32'(i);
      bus.prog_wdata = ref_mem[i];
      @(posedge clk); #1;
    end
    bus.prog_we = 0;
    @(negedge clk);
    chk("reset.stall", 32'(bus.stall_out), 0);
    chk("reset.instr", bus.instr_out, 0);
    chk("reset.fault", 32'(bus.fault_out), 0);
    chk("reset.busy",  32'(bus.busy_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // initial miss, sequential stream, write coherence, out of range, req_en low
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 0, 32'hE3A0_0001, 0, 0));
    tbl.push_back(mk(1, 32'h4,    0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h4,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h4,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h4,    0, 0, 0, 0, 32'h1000_0001, 0, 0));
    tbl.push_back(mk(1, 32'h8,    0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h9,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'hA,    0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'hB,    0, 0, 0, 0, 32'h1000_0002, 0, 0));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 0, 32'h1000_0008, 0, 0));
    tbl.push_back(mk(1, 32'h20,   1, 8, 32'hDEAD_BEEF, 0, 32'h1000_0008, 0, 0));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h20,   0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h0,    0, 0, 0, 1, 0, 0, 0));
    ref_mem[8] = 32'hDEAD_BEEF;
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);
    apply("vec_end.busy", mk(1, 32'h0, 0, 0, 0, 1, 0, 0, 1));
    apply("vec_end.fill", mk(1, 32'h0, 0, 0, 0, 1, 0, 0, 1));
    apply("vec_end.hit",  mk(1, 32'h0, 0, 0, 0, 0, 32'hE3A0_0001, 0, 0));

    // redirect during BUSY: old access completes, new PC then misses on its own
    apply("redir.c0", mk(1, 32'h10, 0, 0, 0, 1, 0, 0, 0));
    apply("redir.c1", mk(1, 32'h40, 0, 0, 0, 1, 0, 0, 1));
    apply("redir.c2", mk(1, 32'h40, 0, 0, 0, 1, 0, 0, 1));
    miss_then_hit("redir.new", 32'h40, 32'h1000_0010, 0);

    // write colliding with the fill of the same word
    apply("coll.c0", mk(1, 32'h14, 0, 0, 0, 1, 0, 0, 0));
    apply("coll.c1", mk(1, 32'h14, 0, 0, 0, 1, 0, 0, 1));
    apply("coll.c2", mk(1, 32'h14, 1, 5, 32'hCAFE_F00D, 1, 0, 0, 1));
    ref_mem[5] = 32'hCAFE_F00D;
    miss_then_hit("coll.refetch", 32'h14, 32'hCAFE_F00D, 0);

    // asynchronous reset in the second BUSY cycle
    apply("rst.c0", mk(1, 32'h30, 0, 0, 0, 1, 0, 0, 0));
    apply("rst.c1", mk(1, 32'h30, 0, 0, 0, 1, 0, 0, 1));
    rst_n = 1'b0;
    #1;
    chk("rst.async.stall", 32'(bus.stall_out), 0);
    chk("rst.async.busy",  32'(bus.busy_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    miss_then_hit("rst.after", 32'h30, 32'h1000_000C, 0);

    // randomized run against the model
    rst_n = 1'b0;
    bus.prog_we = 0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) words[i] = 30'(i);
    words[16] = 30'd1024;
    words[17] = 30'd1025;
    cur_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        req, we, hit;
      logic [31:0] pa, wd;
      if ($urandom_range(0, 99) < 30)
        cur_pc = {words[$urandom_range(0, 17)], 2'($urandom_range(0, 3))};
      req = ($urandom_range(0, 99) < 85);
      we  = ($urandom_range(0, 99) < 10);
      pa  = 32'($urandom_range(0, 15));
      wd  = $urandom;
      bus.req_en = req; bus.pc_in = cur_pc;
      bus.prog_we = we; bus.prog_addr = pa; bus.prog_wdata = wd;
      @(negedge clk);
      hit = m_valid && (m_addr == cur_pc[31:2]);
      chk($sformatf("rnd%0d.stall", n), 32'(bus.stall_out), 32'(req && !hit));
      chk($sformatf("rnd%0d.instr", n), bus.instr_out, hit ? m_data : 32'd0);
      chk($sformatf("rnd%0d.fault", n), 32'(bus.fault_out), 32'(hit && m_fault));
      chk($sformatf("rnd%0d.busy", n),  32'(bus.busy_out), 32'(m_busy));
      model_step(req, cur_pc, we, pa, wd);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
